video_mnist_stat: RTL
=====================

VIDEO_MNIST_STAT -- requirements
Module: video_mnist_stat

Interface
REQ-001 SHALL have parameter TUSER_WIDTH, default 1, meaning AXI4-Stream tuser width (bit 0 is frame start).
REQ-002 SHALL have parameters TNUMBER_WIDTH 4 and TCOUNT_WIDTH 4, meaning class-number and vote-count field widths.
REQ-003 SHALL have parameters CLASS_NUM 10 and COUNT_WIDTH 20, meaning number of classes and per-class counter width.
REQ-004 SHALL have parameters WB_ADR_WIDTH 8, WB_DAT_WIDTH 32 and WB_SEL_WIDTH 4, meaning Wishbone widths.
REQ-005 SHALL have parameters INIT_PARAM_TH 7 and INIT_CTL_ENABLE 1'b1, meaning reset values of the threshold and enable registers.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, on ports aresetn (in, 1, reset) and aclk (in, 1, clock).
REQ-007 SHALL have the stream input s_axi4s_tuser, tlast, tnumber, tcount, tvalid and tready, with tready as the only output (in/out, widths per the parameters).
REQ-008 SHALL have the stream output m_axi4s_tuser, tlast, tnumber, tcount, tvalid and tready, with tready as the only input (out/in, same widths).
REQ-009 SHALL have a Wishbone slave on aclk, with no separate Wishbone clock or reset: s_wb_adr_i, s_wb_dat_i, s_wb_dat_o, s_wb_we_i, s_wb_sel_i, s_wb_stb_i and s_wb_ack_o.
REQ-010 SHALL have port out_frame_done (out, 1), a one-cycle pulse issued when a frame result is latched.

Function
REQ-011 SHALL pass the stream through a one-deep register slice: s_axi4s_tready = ~m_axi4s_tvalid | m_axi4s_tready.
REQ-012 SHALL hold all m_axi4s fields stable while m_axi4s_tvalid=1 and m_axi4s_tready=0.
REQ-013 SHALL give a latency of 1 cycle from accept to m_axi4s_tvalid; accept = s_tvalid & s_tready.
REQ-014 SHALL implement a frame FSM with states IDLE and ACTIVE: in IDLE every beat is ignored except an accepted beat with tuser[0]=1, which moves the FSM to ACTIVE.
REQ-015 SHALL, on an accepted tuser[0]=1 beat in ACTIVE, copy the counters to RESULT_COUNT[i], pulse out_frame_done, and increment FRAME_COUNT with 32-bit wrap.
REQ-016 SHALL, on every accepted tuser[0]=1 beat, clear the counters, then count that beat, and load the working threshold th_act from PARAM_TH.
REQ-017 SHALL count a beat in ACTIVE only if all hold: CTL.enable=1, tnumber<CLASS_NUM, and tcount>=th_act; such a beat increments counter[tnumber].
REQ-018 SHALL saturate each counter at 2^COUNT_WIDTH-1.
REQ-019 SHALL ignore beats with tnumber>=CLASS_NUM; they are still passed through.
REQ-020 SHALL, after each latch, run an argmax scan FSM (SCAN_IDLE, SCAN_RUN) over RESULT_COUNT, one index per cycle, taking CLASS_NUM cycles.
REQ-021 SHALL, at the end of the scan, write RESULT_CLASS and set STATUS.valid; ties SHALL resolve to the lowest index, and all-zero counts SHALL give class 0.
REQ-022 SHALL restart the scan at index 0 if a new latch occurs during SCAN_RUN, and clear STATUS.valid until that scan completes.
REQ-023 SHALL map Wishbone word addresses as follows: 0x00 CORE_ID (RO, constant 0x5254_0100); 0x01 CTL (bit0 enable, RW); 0x02 PARAM_TH (RW, TCOUNT_WIDTH bits).
REQ-024 SHALL map further word addresses: 0x03 STATUS (bit0 valid, bit1 ACTIVE, RO); 0x04 FRAME_COUNT (RO); 0x05 RESULT_CLASS (RO); 0x10+i RESULT_COUNT[i] (RO).
REQ-025 SHALL read unmapped addresses as 0 and ignore writes to them.
REQ-026 SHALL drive s_wb_ack_o = s_wb_stb_i (zero wait), apply writes on stb&we&ack with per-byte s_wb_sel_i, and ignore writes to RO registers.
REQ-027 SHALL apply a PARAM_TH write to counting only at the next frame start.
REQ-028 SHALL apply a CTL.enable write from the next accepted beat.

Reset
REQ-029 SHALL, while aresetn=0: m_axi4s_tvalid=0, other m_axi4s fields 0, s_axi4s_tready=1, out_frame_done=0, FSMs in IDLE and SCAN_IDLE, counters, RESULT_* and FRAME_COUNT 0, STATUS 0.
REQ-030 SHALL reset PARAM_TH and th_act to INIT_PARAM_TH and CTL to INIT_CTL_ENABLE.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame with no latch and no pulse, and require a new tuser beat before counting resumes.

Structure
REQ-032 SHALL place the register address constants, CORE_ID and the FSM state encodings in the shared package video_mnist_pkg.
REQ-033 SHALL split out one sub-module, video_mnist_stat_argmax, containing the scan FSM and its comparator.

Verification
REQ-034 SHALL cover: reset release -> read 0x02 = 7, 0x01 = 1, 0x03 = 0, m_axi4s_tvalid = 0.
REQ-035 SHALL cover: frame of 8 beats with tnumber {3,3,3,1,1,9,12,3} and tcount=8, followed by a tuser beat -> COUNT[3]=4, COUNT[1]=2, COUNT[9]=1, class=3, FRAME_COUNT=1, one pulse.
REQ-036 SHALL cover: PARAM_TH written to 9 mid-frame, beats with tcount=8 -> counted in the current frame, not in the next.
REQ-037 SHALL cover: m_axi4s_tready low for 5 cycles mid-frame -> output held, no beat lost or double-counted, counts equal to the no-stall run.
REQ-038 SHALL cover: COUNT[2]=COUNT[5]=3, plus COUNT_WIDTH=3 with 9 class-4 beats -> class=2, COUNT[4]=7.
REQ-039 SHALL cover: aresetn pulsed low mid-frame, then one full frame -> only the post-reset frame counted, FRAME_COUNT=1.

Source files
------------

// File: rtl/video_mnist_pkg.sv
// Shared constants for the MNIST vote statistics block: register map, core ID
// and the frame / argmax-scan state encodings.
package video_mnist_pkg;

   localparam logic [31:0] CORE_ID = 32'h5254_0100;

   localparam int ADR_CORE_ID      = 'h00;
   localparam int ADR_CTL          = 'h01;
   localparam int ADR_PARAM_TH     = 'h02;
   localparam int ADR_STATUS       = 'h03;
   localparam int ADR_FRAME_COUNT  = 'h04;
   localparam int ADR_RESULT_CLASS = 'h05;
   localparam int ADR_RESULT_BASE  = 'h10;

   typedef enum logic {
      IDLE,
      ACTIVE
   } frame_state_t;

   typedef enum logic {
      SCAN_IDLE,
      SCAN_RUN
   } scan_state_t;

endpackage

// File: rtl/video_mnist_stat_argmax.sv
// Sequential argmax over the latched per-class counts, one class per cycle.
// Ties keep the lowest index; a new start restarts the scan from class 0.
module video_mnist_stat_argmax
   import video_mnist_pkg::*;
#(
   parameter int CLASS_NUM   = 10,
   parameter int COUNT_WIDTH = 20,
   parameter int IDX_W       = 4
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic                             start,
   input  logic [CLASS_NUM*COUNT_WIDTH-1:0] counts,
   output logic [IDX_W-1:0]                 result_class,
   output logic                             valid
);

   scan_state_t            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, best_idx_q;
   logic [COUNT_WIDTH-1:0] best_val_q, cur_val;
   logic                   cur_gt, last_idx;

   assign cur_val  = counts[int'(idx_q)*COUNT_WIDTH +: COUNT_WIDTH];
   assign cur_gt   = cur_val > best_val_q;
   assign last_idx = (int'(idx_q) == CLASS_NUM - 1);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= SCAN_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = SCAN_RUN;
      else if (state_q == SCAN_RUN && last_idx)
         state_d = SCAN_IDLE;
   end

   // scan stage: running best value/index, result written on the last class
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         idx_q        <= '0;
         best_idx_q   <= '0;
         best_val_q   <= '0;
         result_class <= '0;
         valid        <= 1'b0;
      end else if (start) begin
         idx_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         valid      <= 1'b0;
      end else if (state_q == SCAN_RUN) begin
         if (cur_gt) begin
            best_val_q <= cur_val;
            best_idx_q <= idx_q;
         end
         if (last_idx) begin
            result_class <= cur_gt ? idx_q : best_idx_q;
            valid        <= 1'b1;
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/video_mnist_stat.sv
// Per-frame vote histogram of classifier results on a pass-through stream,
// with Wishbone-visible latched counts and the winning class of the last frame.
module video_mnist_stat
   import video_mnist_pkg::*;
#(
   parameter int   TUSER_WIDTH     = 1,
   parameter int   TNUMBER_WIDTH   = 4,
   parameter int   TCOUNT_WIDTH    = 4,
   parameter int   CLASS_NUM       = 10,
   parameter int   COUNT_WIDTH     = 20,
   parameter int   WB_ADR_WIDTH    = 8,
   parameter int   WB_DAT_WIDTH    = 32,
   parameter int   WB_SEL_WIDTH    = 4,
   parameter int   INIT_PARAM_TH   = 7,
   parameter logic INIT_CTL_ENABLE = 1'b1
) (
   input  logic                     aresetn,
   input  logic                     aclk,

   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,

   output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
   output logic                     m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
   output logic                     m_axi4s_tvalid,
   input  logic                     m_axi4s_tready,

   input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
   input  logic                     s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   input  logic                     s_wb_stb_i,
   output logic                     s_wb_ack_o,

   output logic                     out_frame_done
);

   localparam int IDX_W = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;

   frame_state_t                     state_q, state_d;
   logic                             accept, frame_start, in_range, cnt_hit, latch;
   logic [TCOUNT_WIDTH-1:0]          th_use, th_act, param_th;
   logic                             ctl_enable, scan_valid, wb_wr;
   logic [31:0]                      frame_count;
   logic [COUNT_WIDTH-1:0]           cnt        [CLASS_NUM];
   logic [COUNT_WIDTH-1:0]           result_cnt [CLASS_NUM];
   logic [CLASS_NUM*COUNT_WIDTH-1:0] result_flat;
   logic [IDX_W-1:0]                 result_class, rc_sel;
   logic                             unused_bits;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   assign s_axi4s_tready = ~m_axi4s_tvalid | m_axi4s_tready;
   assign accept         = s_axi4s_tvalid & s_axi4s_tready;
   assign frame_start    = accept & s_axi4s_tuser[0];
   assign in_range       = (int'(s_axi4s_tnumber) < CLASS_NUM);
   // a frame-start beat already belongs to the new frame, so it uses the new threshold
   assign th_use         = frame_start ? param_th : th_act;
   assign cnt_hit        = accept & ctl_enable & in_range & (s_axi4s_tcount >= th_use)
                         & (frame_start | (state_q == ACTIVE));
   assign unused_bits    = ^{s_wb_dat_i, s_wb_sel_i, s_axi4s_tuser};

   // output stage: one-deep register slice
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axi4s_tvalid  <= 1'b0;
         m_axi4s_tuser   <= '0;
         m_axi4s_tlast   <= 1'b0;
         m_axi4s_tnumber <= '0;
         m_axi4s_tcount  <= '0;
      end else if (s_axi4s_tready) begin
         m_axi4s_tvalid <= s_axi4s_tvalid;
         if (s_axi4s_tvalid) begin
            m_axi4s_tuser   <= s_axi4s_tuser;
            m_axi4s_tlast   <= s_axi4s_tlast;
            m_axi4s_tnumber <= s_axi4s_tnumber;
            m_axi4s_tcount  <= s_axi4s_tcount;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      if (frame_start) begin
         state_d = ACTIVE;
         latch   = (state_q == ACTIVE);
      end
   end

   // count stage: histogram of the running frame, latched at the next frame start
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < CLASS_NUM; i++) begin
            cnt[i]        <= '0;
            result_cnt[i] <= '0;
         end
         frame_count    <= '0;
         out_frame_done <= 1'b0;
         th_act         <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      end else begin
         out_frame_done <= latch;
         if (latch)       frame_count <= frame_count + 32'd1;
         if (frame_start) th_act      <= param_th;
         for (int i = 0; i < CLASS_NUM; i++) begin
            if (latch) result_cnt[i] <= cnt[i];
            if (frame_start)
               cnt[i] <= (cnt_hit && int'(s_axi4s_tnumber) == i) ? COUNT_WIDTH'(1) : '0;
            else if (cnt_hit && int'(s_axi4s_tnumber) == i)
               cnt[i] <= sat_inc(cnt[i]);
         end
      end
   end

   for (genvar g = 0; g < CLASS_NUM; g++) begin : g_flat
      assign result_flat[g*COUNT_WIDTH +: COUNT_WIDTH] = result_cnt[g];
   end

   video_mnist_stat_argmax #(
      .CLASS_NUM   (CLASS_NUM),
      .COUNT_WIDTH (COUNT_WIDTH),
      .IDX_W       (IDX_W)
   ) u_argmax (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .start        (out_frame_done),
      .counts       (result_flat),
      .result_class (result_class),
      .valid        (scan_valid)
   );

   assign s_wb_ack_o = s_wb_stb_i;
   assign wb_wr      = s_wb_stb_i & s_wb_we_i & s_wb_ack_o;
   assign rc_sel     = IDX_W'(int'(s_wb_adr_i) - ADR_RESULT_BASE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ctl_enable <= INIT_CTL_ENABLE;
         param_th   <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      end else if (wb_wr) begin
         if (int'(s_wb_adr_i) == ADR_CTL && s_wb_sel_i[0])
            ctl_enable <= s_wb_dat_i[0];
         if (int'(s_wb_adr_i) == ADR_PARAM_TH)
            for (int b = 0; b < TCOUNT_WIDTH; b++)
               if (s_wb_sel_i[b/8]) param_th[b] <= s_wb_dat_i[b];
      end
   end

   always_comb begin
      s_wb_dat_o = '0;
      case (int'(s_wb_adr_i))
         ADR_CORE_ID:      s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
         ADR_CTL:          s_wb_dat_o[0] = ctl_enable;
         ADR_PARAM_TH:     s_wb_dat_o[TCOUNT_WIDTH-1:0] = param_th;
         ADR_STATUS:       s_wb_dat_o[1:0] = {state_q == ACTIVE, scan_valid};
         ADR_FRAME_COUNT:  s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
         ADR_RESULT_CLASS: s_wb_dat_o[IDX_W-1:0] = result_class;
         default: begin
            if (int'(s_wb_adr_i) >= ADR_RESULT_BASE &&
                int'(s_wb_adr_i) <  ADR_RESULT_BASE + CLASS_NUM)
               s_wb_dat_o[COUNT_WIDTH-1:0] = result_cnt[rc_sel];
         end
      endcase
   end

endmodule
